// File: rtl/qu_rob.sv
// rtl/qu_rob.sv - reorder buffer with in-order commit and operand bypass
//
// Ports:
//   clk, rst_n          sole rising-edge clock, synchronous active-low reset
//   flush               discard every entry, pointers and count back to zero
//   alloc_valid/_dest   dispatch request and physical destination of the new entry
//   alloc_ready         an entry is free (registered count only)
//   alloc_rob_addr      index the next allocation receives (tail)
//   wb_valid/_rob_addr  result broadcast and the entry it belongs to
//   wb_value            result value
//   rd_addr_j/_k        operand lookup indices
//   rd_value_j/_k       looked-up value (writeback bypassed when it hits)
//   rd_ready_j/_k       looked-up value is valid
//   commit_valid        head entry holds a result and may retire
//   commit_ready        register-file write accepted
//   commit_dest/_value  head destination and value
//   commit_rob_addr     head index
//   count, empty        occupied entries, count == 0

module qu_rob #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int PW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          alloc_valid,
  input  logic [PW-1:0] alloc_dest,
  output logic          alloc_ready,
  output logic [AW-1:0] alloc_rob_addr,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rob_addr,
  input  logic [31:0]   wb_value,
  input  logic [AW-1:0] rd_addr_j,
  input  logic [AW-1:0] rd_addr_k,
  output logic [31:0]   rd_value_j,
  output logic [31:0]   rd_value_k,
  output logic          rd_ready_j,
  output logic          rd_ready_k,
  output logic          commit_valid,
  input  logic          commit_ready,
  output logic [PW-1:0] commit_dest,
  output logic [31:0]   commit_value,
  output logic [AW-1:0] commit_rob_addr,
  output logic [AW:0]   count,
  output logic          empty
);

  // Entry state codes. 01 (retired) is reserved and never written: an entry
  // goes straight from EXECUTE back to EMPTY when it commits.
  localparam logic [1:0] ST_EMPTY   = 2'b00;
  localparam logic [1:0] ST_EXECUTE = 2'b10;
  localparam logic [1:0] ST_PENDING = 2'b11;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0]   value;
    logic [PW-1:0] dest;
    logic [1:0]    state;
  } rob_cell_t;

  rob_cell_t     cells [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count_q;

  logic alloc_fire;
  logic commit_fire;
  logic wb_hit;

  // alloc_ready looks only at the registered count, so a commit in the same
  // cycle cannot free a slot for a simultaneous allocation.
  assign alloc_ready    = (count_q < FULL_COUNT);
  assign alloc_rob_addr = tail;
  assign alloc_fire     = alloc_valid & alloc_ready;

  // The head only becomes committable once its writeback has been registered,
  // so a writeback to the head shows up as commit_valid one cycle later.
  assign commit_valid    = (count_q != '0) & (cells[head].state == ST_EXECUTE);
  assign commit_fire     = commit_valid & commit_ready;
  assign commit_dest     = cells[head].dest;
  assign commit_value    = cells[head].value;
  assign commit_rob_addr = head;

  // Writebacks to EMPTY or EXECUTE cells are stale or duplicate and dropped.
  assign wb_hit = wb_valid & (cells[wb_rob_addr].state == ST_PENDING);

  assign count = count_q;
  assign empty = (count_q == '0);

  // Operand lookup: a writeback landing on a pending entry this very cycle is
  // forwarded so dispatch does not wait for it to reach storage.
  always_comb begin
    rd_value_j = cells[rd_addr_j].value;
    rd_ready_j = (cells[rd_addr_j].state == ST_EXECUTE);
    if (wb_valid && (wb_rob_addr == rd_addr_j) && (cells[rd_addr_j].state == ST_PENDING)) begin
      rd_value_j = wb_value;
      rd_ready_j = 1'b1;
    end
  end

  always_comb begin
    rd_value_k = cells[rd_addr_k].value;
    rd_ready_k = (cells[rd_addr_k].state == ST_EXECUTE);
    if (wb_valid && (wb_rob_addr == rd_addr_k) && (cells[rd_addr_k].state == ST_PENDING)) begin
      rd_value_k = wb_value;
      rd_ready_k = 1'b1;
    end
  end

  // Pointer and count bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (commit_fire) begin
        head <= head + AW'(1);
      end
      if (alloc_fire) begin
        tail <= tail + AW'(1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Cell storage. Alloc, writeback and commit never touch the same cell in
  // one cycle: the tail cell is EMPTY when alloc fires, the head cell is
  // EXECUTE when commit fires, and writebacks only act on PENDING cells.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cells[i] <= '0;
      end
    end else if (flush) begin
      // Only the state is cleared; value/dest are left as they were.
      for (int i = 0; i < DEPTH; i++) begin
        cells[i].state <= ST_EMPTY;
      end
    end else begin
      if (wb_hit) begin
        cells[wb_rob_addr].value <= wb_value;
        cells[wb_rob_addr].state <= ST_EXECUTE;
      end
      if (commit_fire) begin
        cells[head].state <= ST_EMPTY;
      end
      if (alloc_fire) begin
        cells[tail].value <= '0;
        cells[tail].dest  <= alloc_dest;
        cells[tail].state <= ST_PENDING;
      end
    end
  end

endmodule
